tqvp_vga_timing_gen: RTL

TQVP_VGA_TIMING_GEN -- requirements
Module: tqvp_vga_timing_gen

---
 rtl/tqvp_vga_pkg.sv | 45 ++++
 rtl/tqvp_vga_axis.sv | 68 ++++++
 rtl/tqvp_vga_timing_gen.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/tqvp_vga_pkg.sv
// VGA timing generator shared definitions:
// register map, pattern codes and segment layout.
package tqvp_vga_pkg;

  localparam int A_SEG_END = 'h10;
  localparam int A_CTRL    = 'h10;
  localparam int A_COLOR   = 'h11;
  localparam int A_STATUS  = 'h12;
  localparam int A_FRM_LO  = 'h13;
  localparam int A_FRM_HI  = 'h14;
  localparam int A_COMMIT  = 'h15;

  localparam logic [7:0] CTRL_MASK  = 8'h3D;
  localparam logic [7:0] CTRL_RESET = 8'h01;

  typedef enum logic [2:0] {
    PAT_BLACK  = 3'd0,
    PAT_GRAD   = 3'd1,
    PAT_BORDER = 3'd2,
    PAT_SOLID  = 3'd3,
    PAT_CHECK  = 3'd4,
    PAT_BARS   = 3'd5
  } pattern_e;

  // Even byte carries the flags and len[12:8], odd byte len[7:0].
  typedef struct packed {
    logic        sync;
    logic        active;
    logic        advance;
    logic [12:0] len;
  } seg_t;

  function automatic logic [7:0] seg_byte_mask(
    input int   seg_w,
    input logic odd
  );
    logic [7:0] m;
    for (int i = 0; i < 8; i++) begin
      if (odd) m[i] = (i < seg_w);
      else     m[i] = (i >= 5) || (i + 8 < seg_w);
    end
    return m;
  endfunction

endpackage

// File: rtl/tqvp_vga_axis.sv
// One timing axis: four segments run cyclically,
// each lasting max(len,1) ticks.
module tqvp_vga_axis
  import tqvp_vga_pkg::*;
#(
  parameter int SEG_W = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             tick_i,
  input  seg_t [3:0]       segs_i,
  output logic [SEG_W-1:0] pos_o,
  output logic [SEG_W-1:0] rem_o,
  output logic             sync_o,
  output logic             active_o,
  output logic             advance_o,
  output logic             last_tick_o
);

  logic [1:0]       phase_q, phase_d;
  logic [SEG_W-1:0] pos_q, pos_d;
  logic [SEG_W-1:0] len, lenm1;
  logic             last;
  logic             unused_len;
  seg_t             seg;

  assign seg   = segs_i[phase_q];
  assign len   = seg.len[SEG_W-1:0];
  assign lenm1 = (len == '0) ? '0 : len - SEG_W'(1);
  // >= keeps a shortened segment from overrunning
  assign last  = (pos_q >= lenm1);

  assign unused_len  = ^seg.len;
  assign pos_o       = pos_q;
  assign rem_o       = last ? '0 : lenm1 - pos_q;
  assign sync_o      = seg.sync;
  assign active_o    = seg.active;
  assign advance_o   = seg.advance;
  assign last_tick_o = last;

  always_comb begin
    phase_d = phase_q;
    pos_d   = pos_q;
    if (clr_i) begin
      phase_d = '0;
      pos_d   = '0;
    end else if (tick_i) begin
      if (last) begin
        pos_d   = '0;
        phase_d = phase_q + 2'd1;
      end else begin
        pos_d = pos_q + SEG_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      pos_q   <= '0;
    end else begin
      phase_q <= phase_d;
      pos_q   <= pos_d;
    end
  end

endmodule

// File: rtl/tqvp_vga_timing_gen.sv
// Programmable VGA timing generator with shadowed
// segment registers, test patterns and frame IRQ.
module tqvp_vga_timing_gen
  import tqvp_vga_pkg::*;
#(
  parameter int SEG_W   = 13,
  parameter int ADDR_W  = 5,
  parameter int FRAME_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        ui_in,
  output logic [7:0]        uo_out,
  input  logic [ADDR_W-1:0] address,
  input  logic              data_write,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic              frame_irq
);

  logic [15:0][7:0]   sh_q, sh_d, wk_q, wk_d;
  logic [7:0]         ctrl_q, ctrl_d;
  logic [5:0]         color_q, color_d;
  logic               pend_q, pend_d;
  logic               flag_q, flag_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [7:0]         uo_q, uo_d;
  logic               irq_q;

  logic [31:0]      a32;
  logic             seg_acc, restart, commit_wr;
  logic             en, apply_mode, frame_end;
  logic [15:0]      frame16;
  seg_t [3:0]       h_segs, v_segs;
  logic [SEG_W-1:0] h_pos, h_rem, v_pos, v_rem;
  logic             h_sync, h_act, h_adv, h_last;
  logic             v_sync, v_act, v_adv, v_last;
  logic             hs, vs, act, v_tick;
  logic [8:0]       hx, vx;
  logic [5:0]       rgb;
  logic             unused_ok;

  assign a32        = 32'(address);
  assign seg_acc    = (a32 < A_SEG_END);
  assign en         = ctrl_q[0];
  assign apply_mode = ctrl_q[2];
  assign commit_wr  = data_write && (a32 == A_COMMIT);
  assign frame16    = 16'(frame_q);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      h_segs[i] = {wk_q[2*i], wk_q[2*i+1]};
      v_segs[i] = {wk_q[8+2*i], wk_q[9+2*i]};
    end
  end

  tqvp_vga_axis #(.SEG_W(SEG_W)) u_h (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (restart | ~en),
    .tick_i      (en),
    .segs_i      (h_segs),
    .pos_o       (h_pos),
    .rem_o       (h_rem),
    .sync_o      (h_sync),
    .active_o    (h_act),
    .advance_o   (h_adv),
    .last_tick_o (h_last)
  );

  tqvp_vga_axis #(.SEG_W(SEG_W)) u_v (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (restart | ~en),
    .tick_i      (v_tick),
    .segs_i      (v_segs),
    .pos_o       (v_pos),
    .rem_o       (v_rem),
    .sync_o      (v_sync),
    .active_o    (v_act),
    .advance_o   (v_adv),
    .last_tick_o (v_last)
  );

  assign v_tick    = en & h_last & h_adv;
  assign frame_end = v_tick & v_last & v_adv;
  assign hs        = en & h_sync;
  assign vs        = en & v_sync;
  assign act       = en & h_act & v_act;

  always_comb begin
    sh_d    = sh_q;
    wk_d    = wk_q;
    ctrl_d  = ctrl_q;
    color_d = color_q;
    pend_d  = pend_q;
    flag_d  = flag_q;
    frame_d = frame_q;
    restart = 1'b0;
    if (data_write) begin
      if (seg_acc) begin
        sh_d[a32[3:0]] = data_in & seg_byte_mask(SEG_W, a32[0]);
        restart        = ~apply_mode;
      end else begin
        case (a32)
          A_CTRL: begin
            ctrl_d = data_in & CTRL_MASK;
            if (!data_in[2]) pend_d = 1'b0;
          end
          A_COLOR:  color_d = data_in[5:0];
          A_STATUS: if (data_in[3]) flag_d = 1'b0;
          A_COMMIT: pend_d = 1'b1;
          default:  ;
        endcase
      end
    end
    if (frame_end) begin
      frame_d = frame_q + FRAME_W'(1);
      flag_d  = 1'b1;
      // A commit landing now only takes effect next frame
      if (pend_q) begin
        wk_d = sh_q;
        if (!commit_wr) pend_d = 1'b0;
      end
    end
    if (restart) wk_d = sh_d;
  end

  assign hx = 9'(h_pos);
  assign vx = 9'(v_pos);

  always_comb begin
    rgb = '0;
    case (pattern_e'(ctrl_q[5:3]))
      PAT_GRAD:
        rgb = {hx[7], vx[7], hx[6], vx[8], vx[6], hx[8]};
      PAT_BORDER:
        if (h_pos < SEG_W'(2) || h_rem < SEG_W'(2) ||
            v_pos < SEG_W'(2) || v_rem < SEG_W'(2))
          rgb = '1;
      PAT_SOLID: rgb = color_q;
      PAT_CHECK: if (hx[3] ^ vx[3]) rgb = '1;
      PAT_BARS:
        rgb = {{2{hx[8]}}, {2{hx[7]}}, {2{hx[6]}}};
      default: rgb = '0;
    endcase
    if (!act) rgb = '0;
  end

  assign uo_d = {hs, rgb[0], rgb[2], rgb[4],
                 vs, rgb[1], rgb[3], rgb[5]};

  always_comb begin
    data_out = '0;
    if (seg_acc) begin
      data_out = sh_q[a32[3:0]];
    end else begin
      case (a32)
        A_CTRL:   data_out = ctrl_q;
        A_COLOR:  data_out = {2'b0, color_q};
        A_STATUS: data_out = {4'b0, flag_q, vs, hs, act};
        A_FRM_LO: data_out = frame16[7:0];
        A_FRM_HI: data_out = frame16[15:8];
        default:  data_out = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q    <= '0;
      wk_q    <= '0;
      ctrl_q  <= CTRL_RESET;
      color_q <= '0;
      pend_q  <= 1'b0;
      flag_q  <= 1'b0;
      frame_q <= '0;
      uo_q    <= '0;
      irq_q   <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      wk_q    <= wk_d;
      ctrl_q  <= ctrl_d;
      color_q <= color_d;
      pend_q  <= pend_d;
      flag_q  <= flag_d;
      frame_q <= frame_d;
      uo_q    <= en ? uo_d : '0;
      irq_q   <= frame_end;
    end
  end

  assign uo_out    = uo_q;
  assign frame_irq = irq_q;
  assign unused_ok = ^{ui_in, hx, vx, a32};

endmodule
